// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and helpers for the decode-stage register file and its
// pending-write scoreboard.
//
// Contents:
//   clog2()          - ceiling log2, used to size register indices
//   REG_ZERO         - index of the hard-wired zero register
//   SIM_EXIT_VALUE   - write-back value that raises sim_exit_o when the
//                      optional exit feature (REGFILE_SIM_EXIT_EN) is built
//   DEFAULT_SP_IDX   - register that comes out of reset non-zero
//   DEFAULT_SP_INIT  - its reset value
// ----------------------------------------------------------------------------
package regfile_pkg;

   localparam int          REG_ZERO        = 0;
   localparam int          SIM_EXIT_VALUE  = 57005;
   localparam int          DEFAULT_SP_IDX  = 2;
   localparam logic [31:0] DEFAULT_SP_INIT = 32'h0001_2000;

   // Ceiling log2; clog2(1) is 0, clog2(2) is 1, clog2(32) is 5.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) begin
         r++;
      end
      return r;
   endfunction

endpackage : regfile_pkg

// File: rtl/regfile_sb.sv
// ----------------------------------------------------------------------------
// regfile_sb
// Pending-write scoreboard: one bit per architectural register, set when an
// instruction that writes that register issues, cleared when its result is
// written back. Generates the combinational issue stall.
//
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   rd_addr_i       - NRD source indices, port k at [k*AW +: AW]
//   src_use_i       - per-port "this source is really read" flag
//   issue_valid_i   - an instruction requests issue this cycle
//   issue_rd_i      - destination index of the issuing instruction
//   issue_wr_i      - issuing instruction writes a destination
//   wb_valid_i      - write-back strobe
//   wb_addr_i       - write-back index
//   stall_o         - issue blocked this cycle (combinational)
// ----------------------------------------------------------------------------
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int NREG = 32,
   parameter int NRD  = 2,
   parameter int AW   = clog2(NREG)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NRD*AW-1:0] rd_addr_i,
   input  logic [NRD-1:0]    src_use_i,
   input  logic              issue_valid_i,
   input  logic [AW-1:0]     issue_rd_i,
   input  logic              issue_wr_i,
   input  logic              wb_valid_i,
   input  logic [AW-1:0]     wb_addr_i,
   output logic              stall_o
);

   localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);

   logic [NREG-1:0] pend_q, pend_d;
   logic [NRD-1:0]  hazard;

   // A source is hazardous only while its producer is outstanding; a
   // write-back landing on that index this very cycle is bypassed into the
   // read, so it does not block.
   always_comb begin
      hazard = '0;
      for (int k = 0; k < NRD; k++) begin
         hazard[k] = src_use_i[k]
                   & pend_q[rd_addr_i[k*AW +: AW]]
                   & ~(wb_valid_i & (wb_addr_i == rd_addr_i[k*AW +: AW]));
      end
   end

   assign stall_o = issue_valid_i & (|hazard);

   // Clear on write-back first, then set on issue: when both hit the same
   // index the newer producer is the one still outstanding.
   always_comb begin
      pend_d = pend_q;
      if (wb_valid_i && (wb_addr_i != ZERO_IDX)) begin
         pend_d[wb_addr_i] = 1'b0;
      end
      if (issue_valid_i && !stall_o && issue_wr_i && (issue_rd_i != ZERO_IDX)) begin
         pend_d[issue_rd_i] = 1'b1;
      end
   end

   // NOTE: state flops take only non-blocking assignments; the next-state
   // value is fully formed in the always_comb above, so ordering between
   // always_ff blocks can never matter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

endmodule : regfile_sb

// File: rtl/regfile_scoreboard.sv
// ----------------------------------------------------------------------------
// regfile_scoreboard
// NREG x XLEN integer register file with NRD registered read ports, one
// write-back port with same-cycle bypass, and a pending-write scoreboard
// (regfile_sb) that stalls issue on an outstanding source.
//
// Ports:
//   clk            - clock, all state updates on posedge
//   reset          - asynchronous active-low reset
//   rd_en_i        - capture read data this edge
//   rd_addr_i      - NRD source indices, port k at [k*AW +: AW]
//   rd_data_o      - registered operand data, port k at [k*XLEN +: XLEN]
//   src_use_i      - per-port flag: the issuing instruction reads this source
//   issue_valid_i  - an instruction requests issue this cycle
//   issue_rd_i     - destination index of the issuing instruction
//   issue_wr_i     - issuing instruction writes a destination
//   stall_o        - issue blocked this cycle (combinational)
//   wb_valid_i     - write-back strobe
//   wb_addr_i      - write-back index
//   wb_data_i      - write-back data
//   sim_exit_o     - sticky simulation-exit flag
//
// Build option REGFILE_SIM_EXIT_EN: when defined, a write-back of
// SIM_EXIT_VALUE to register NREG-1 sets sim_exit_o and the simulation
// finishes one cycle later. When undefined, sim_exit_o is tied low.
// ----------------------------------------------------------------------------
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int              XLEN    = 32,
   parameter int              NREG    = 32,
   parameter int              NRD     = 2,
   parameter int              SP_IDX  = DEFAULT_SP_IDX,
   parameter logic [XLEN-1:0] SP_INIT = XLEN'(DEFAULT_SP_INIT),
   localparam int             AW      = clog2(NREG)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                rd_en_i,
   input  logic [NRD*AW-1:0]   rd_addr_i,
   output logic [NRD*XLEN-1:0] rd_data_o,
   input  logic [NRD-1:0]      src_use_i,
   input  logic                issue_valid_i,
   input  logic [AW-1:0]       issue_rd_i,
   input  logic                issue_wr_i,
   output logic                stall_o,
   input  logic                wb_valid_i,
   input  logic [AW-1:0]       wb_addr_i,
   input  logic [XLEN-1:0]     wb_data_i,
   output logic                sim_exit_o
);

   localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);

   logic [XLEN-1:0]     reg_q [NREG];
   logic [XLEN-1:0]     reg_d [NREG];
   logic [NRD*XLEN-1:0] rd_data_q, rd_data_d;
   logic                wr_en;

   // Register 0 is never written, so it stays at its reset value of zero.
   assign wr_en = wb_valid_i && (wb_addr_i != ZERO_IDX);

   always_comb begin
      reg_d = reg_q;
      if (wr_en) begin
         reg_d[wb_addr_i] = wb_data_i;
      end
   end

   // NOTE: this register file is built from flops rather than a RAM macro,
   // and every entry is reset so the stack pointer starts valid and no
   // operand ever reads X; that rules out mapping it onto SRAM.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) begin
            reg_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
         end
      end else begin
         reg_q <= reg_d;
      end
   end

   // Operand capture: zero register, then same-cycle write-back bypass,
   // then the stored value. Holds when rd_en_i is low.
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en_i) begin
         for (int k = 0; k < NRD; k++) begin
            if (rd_addr_i[k*AW +: AW] == ZERO_IDX) begin
               rd_data_d[k*XLEN +: XLEN] = '0;
            end else if (wb_valid_i && (wb_addr_i == rd_addr_i[k*AW +: AW])) begin
               rd_data_d[k*XLEN +: XLEN] = wb_data_i;
            end else begin
               rd_data_d[k*XLEN +: XLEN] = reg_q[rd_addr_i[k*AW +: AW]];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data_o = rd_data_q;

   regfile_sb #(
      .NREG (NREG),
      .NRD  (NRD),
      .AW   (AW)
   ) u_sb (
      .clk           (clk),
      .reset         (reset),
      .rd_addr_i     (rd_addr_i),
      .src_use_i     (src_use_i),
      .issue_valid_i (issue_valid_i),
      .issue_rd_i    (issue_rd_i),
      .issue_wr_i    (issue_wr_i),
      .wb_valid_i    (wb_valid_i),
      .wb_addr_i     (wb_addr_i),
      .stall_o       (stall_o)
   );

`ifdef REGFILE_SIM_EXIT_EN
   logic sim_exit_q, sim_exit_d;

   always_comb begin
      sim_exit_d = sim_exit_q;
      if (wb_valid_i && (wb_addr_i == AW'(NREG - 1))
          && (wb_data_i == XLEN'(SIM_EXIT_VALUE))) begin
         sim_exit_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sim_exit_q <= 1'b0;
      end else begin
         sim_exit_q <= sim_exit_d;
      end
   end

   // The flag is visible for one full cycle before the run ends.
   always_ff @(posedge clk) begin
      if (reset && sim_exit_q) begin
         $finish;
      end
   end

   assign sim_exit_o = sim_exit_q;
`else
   assign sim_exit_o = 1'b0;
`endif

endmodule : regfile_scoreboard
